// File: rtl/ibex_pkg.sv
// Shared types and address-space helpers for the register-file writeback path.
package ibex_pkg;

  localparam int unsigned RfWbDataW = 32;

  // One buffered register-file write.
  typedef struct packed {
    logic [4:0]           waddr;
    logic [RfWbDataW-1:0] wdata;
  } rf_wb_req_t;

  // RV32E has 16 architectural registers; address bit 4 is ignored.
  function automatic int unsigned rf_addr_width(input bit rv32e);
    return rv32e ? 32'd4 : 32'd5;
  endfunction

  function automatic int unsigned rf_num_words(input bit rv32e);
    return 32'd1 << rf_addr_width(rv32e);
  endfunction

endpackage

// File: rtl/ibex_rf_wb_fifo.sv
// Small circular FIFO of pending LSU writebacks. Every slot and its valid bit
// are exposed so the owner can build a pending-write scoreboard.
module ibex_rf_wb_fifo
  import ibex_pkg::*;
#(
  parameter int unsigned Depth = 2,
  parameter type         T     = rf_wb_req_t
) (
  input  logic             clk_int,
  input  logic             rst_ni,
  input  logic             i_push_valid,
  output logic             o_push_ready,
  input  T                 i_push_data,
  input  logic             i_pop,
  output T                 o_head,
  output logic             o_empty,
  output T     [Depth-1:0] o_entries,
  output logic [Depth-1:0] o_entry_vld
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

  T     [Depth-1:0] r_mem;
  logic [PtrW-1:0]  r_wptr;
  logic [PtrW-1:0]  r_rptr;
  logic [CntW-1:0]  r_cnt;

  logic w_push;
  logic w_pop;

  // Readiness depends only on stored occupancy, never on a same-cycle pop.
  assign o_push_ready = (r_cnt != FullCnt);
  assign o_empty      = (r_cnt == '0);
  assign w_push       = i_push_valid && o_push_ready;
  assign w_pop        = i_pop && !o_empty;
  assign o_head       = r_mem[r_rptr];
  assign o_entries    = r_mem;

  // Storage, pointers (wrapping modulo Depth) and occupancy count.
  always_ff @(posedge clk_int or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mem  <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_push_data;
        r_wptr        <= (r_wptr == LastPtr) ? '0 : r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= (r_rptr == LastPtr) ? '0 : r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // A slot is live when its distance from the read pointer is below the count.
  always_comb begin
    o_entry_vld = '0;
    for (int i = 0; i < int'(Depth); i++) begin
      int off;
      off = (i + int'(Depth) - int'(r_rptr)) % int'(Depth);
      o_entry_vld[i] = (off < int'(r_cnt));
    end
  end

endmodule

// File: rtl/ibex_rf_wb_arbiter.sv
// Register-file write-port arbiter: EX results win over buffered LSU loads,
// and a pending-write mask lets decode stall on hazards against them.
module ibex_rf_wb_arbiter
  import ibex_pkg::*;
#(
  parameter bit          RV32E     = 1'b0,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned LsuDepth  = 2
) (
  input  logic                              clk_int,
  input  logic                              rst_ni,
  input  logic                              ex_we_i,
  input  logic [4:0]                        ex_waddr_i,
  input  logic [DataWidth-1:0]              ex_wdata_i,
  input  logic                              lsu_valid_i,
  output logic                              lsu_ready_o,
  input  logic [4:0]                        lsu_waddr_i,
  input  logic [DataWidth-1:0]              lsu_wdata_i,
  input  logic [4:0]                        raddr_a_i,
  input  logic [4:0]                        raddr_b_i,
  output logic                              hazard_a_o,
  output logic                              hazard_b_o,
  output logic [rf_num_words(RV32E)-1:0]    pend_mask_o,
  output logic                              rf_we_o,
  output logic [4:0]                        rf_waddr_o,
  output logic [DataWidth-1:0]              rf_wdata_o
);

  localparam int unsigned AddrW    = rf_addr_width(RV32E);
  localparam int unsigned NumWords = rf_num_words(RV32E);
  localparam logic [4:0]  AddrMask = 5'(NumWords - 1);

  typedef struct packed {
    logic [4:0]           waddr;
    logic [DataWidth-1:0] wdata;
  } req_t;

  logic                    w_ex_vld;
  logic [4:0]              w_ex_addr;
  logic [4:0]              w_lsu_addr;
  logic                    w_push_valid;
  logic                    w_fifo_ready;
  logic                    w_fifo_empty;
  logic                    w_pop;
  req_t                    w_push_req;
  req_t                    w_head;
  req_t [LsuDepth-1:0]     w_entries;
  logic [LsuDepth-1:0]     w_entry_vld;
  logic [NumWords-1:0]     w_pend;

  logic                    r_we;
  logic [4:0]              r_waddr;
  logic [DataWidth-1:0]    r_wdata;

  assign w_ex_addr  = ex_waddr_i & AddrMask;
  assign w_lsu_addr = lsu_waddr_i & AddrMask;
  // Writes to x0 are dropped; an LSU x0 load still handshakes but stores nothing.
  assign w_ex_vld     = ex_we_i && (w_ex_addr != '0);
  assign w_push_valid = lsu_valid_i && (w_lsu_addr != '0);
  assign w_push_req   = '{waddr: w_lsu_addr, wdata: lsu_wdata_i};
  assign lsu_ready_o  = w_fifo_ready;
  // EX has fixed priority; the FIFO only drains on cycles EX leaves free.
  assign w_pop        = !w_ex_vld && !w_fifo_empty;

  ibex_rf_wb_fifo #(
    .Depth (LsuDepth),
    .T     (req_t)
  ) u_lsu_fifo (
    .clk_int      (clk_int),
    .rst_ni       (rst_ni),
    .i_push_valid (w_push_valid),
    .o_push_ready (w_fifo_ready),
    .i_push_data  (w_push_req),
    .i_pop        (w_pop),
    .o_head       (w_head),
    .o_empty      (w_fifo_empty),
    .o_entries    (w_entries),
    .o_entry_vld  (w_entry_vld)
  );

  // Registered write request; address/data hold when idle.
  always_ff @(posedge clk_int or negedge rst_ni) begin
    if (!rst_ni) begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else if (w_ex_vld) begin
      r_we    <= 1'b1;
      r_waddr <= w_ex_addr;
      r_wdata <= ex_wdata_i;
    end else if (w_pop) begin
      r_we    <= 1'b1;
      r_waddr <= w_head.waddr;
      r_wdata <= w_head.wdata;
    end else begin
      r_we    <= 1'b0;
    end
  end

  // Pending-write scoreboard: buffered loads plus the write in the output stage.
  always_comb begin
    w_pend = '0;
    for (int i = 0; i < int'(LsuDepth); i++) begin
      if (w_entry_vld[i]) w_pend[w_entries[i].waddr[AddrW-1:0]] = 1'b1;
    end
    if (r_we) w_pend[r_waddr[AddrW-1:0]] = 1'b1;
    w_pend[0] = 1'b0;
  end

  assign pend_mask_o = w_pend;
  assign hazard_a_o  = w_pend[raddr_a_i[AddrW-1:0]];
  assign hazard_b_o  = w_pend[raddr_b_i[AddrW-1:0]];
  assign rf_we_o     = r_we;
  assign rf_waddr_o  = r_waddr;
  assign rf_wdata_o  = r_wdata;

  // EX must not overwrite a register that still has a write in flight (WAW).
  ap_no_waw: assert property (@(posedge clk_int) disable iff (!rst_ni)
    !(w_ex_vld && w_pend[w_ex_addr[AddrW-1:0]]));

endmodule

// File: tb/tb_ibex_rf_wb_arbiter.sv
// Randomized bench for ibex_rf_wb_arbiter against a queue-based reference.
module tb_ibex_rf_wb_arbiter;

  localparam bit RV32E = 1'b1;
  localparam int DW    = 32;
  localparam int DEPTH = 2;
  localparam int NW    = RV32E ? 16 : 32;

  logic          clk_int = 1'b0;
  logic          rst_ni  = 1'b0;
  logic          ex_we_i = 1'b0;
  logic [4:0]    ex_waddr_i = '0;
  logic [DW-1:0] ex_wdata_i = '0;
  logic          lsu_valid_i = 1'b0;
  logic          lsu_ready_o;
  logic [4:0]    lsu_waddr_i = '0;
  logic [DW-1:0] lsu_wdata_i = '0;
  logic [4:0]    raddr_a_i = '0;
  logic [4:0]    raddr_b_i = '0;
  logic          hazard_a_o, hazard_b_o;
  logic [NW-1:0] pend_mask_o;
  logic          rf_we_o;
  logic [4:0]    rf_waddr_o;
  logic [DW-1:0] rf_wdata_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_int = ~clk_int;

  ibex_rf_wb_arbiter #(.RV32E(RV32E), .DataWidth(DW), .LsuDepth(DEPTH)) dut (
    .clk_int(clk_int), .rst_ni(rst_ni),
    .ex_we_i(ex_we_i), .ex_waddr_i(ex_waddr_i), .ex_wdata_i(ex_wdata_i),
    .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o),
    .lsu_waddr_i(lsu_waddr_i), .lsu_wdata_i(lsu_wdata_i),
    .raddr_a_i(raddr_a_i), .raddr_b_i(raddr_b_i),
    .hazard_a_o(hazard_a_o), .hazard_b_o(hazard_b_o), .pend_mask_o(pend_mask_o),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o)
  );

  // Reference model: queue of buffered loads and the expected output register.
  typedef struct { logic [4:0] a; logic [DW-1:0] d; } ent_t;
  ent_t          q[$];
  logic          m_we   = 1'b0;
  logic [4:0]    m_addr = '0;
  logic [DW-1:0] m_data = '0;

  function automatic logic [4:0] msk(input logic [4:0] a);
    return RV32E ? {1'b0, a[3:0]} : a;
  endfunction

  function automatic logic [NW-1:0] model_pend();
    logic [NW-1:0] p;
    p = '0;
    foreach (q[i]) p[msk(q[i].a)] = 1'b1;
    if (m_we) p[msk(m_addr)] = 1'b1;
    p[0] = 1'b0;
    return p;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [NW-1:0] p;
    p = model_pend();
    chk("rf_we", 64'(rf_we_o), 64'(m_we));
    chk("rf_waddr", 64'(rf_waddr_o), 64'(m_addr));
    chk("rf_wdata", 64'(rf_wdata_o), 64'(m_data));
    chk("lsu_ready", 64'(lsu_ready_o), 64'(q.size() < DEPTH));
    chk("pend_mask", 64'(pend_mask_o), 64'(p));
    chk("hazard_a", 64'(hazard_a_o), 64'(p[msk(raddr_a_i)]));
    chk("hazard_b", 64'(hazard_b_o), 64'(p[msk(raddr_b_i)]));
  endtask

  // Apply one cycle of stimulus, advance the model across the edge, then check.
  task automatic step(input logic ew, input logic [4:0] ea, input logic [DW-1:0] ed,
                      input logic lv, input logic [4:0] la, input logic [DW-1:0] ld);
    logic accept;
    ent_t e;
    ex_we_i = ew; ex_waddr_i = ea; ex_wdata_i = ed;
    lsu_valid_i = lv; lsu_waddr_i = la; lsu_wdata_i = ld;
    accept = lv && (q.size() < DEPTH);
    @(posedge clk_int);
    if (ew && msk(ea) != 5'd0) begin
      m_we = 1'b1; m_addr = msk(ea); m_data = ed;
    end else if (q.size() > 0) begin
      e = q.pop_front();
      m_we = 1'b1; m_addr = msk(e.a); m_data = e.d;
    end else begin
      m_we = 1'b0;
    end
    if (accept && msk(la) != 5'd0) begin
      e.a = msk(la); e.d = ld;
      q.push_back(e);
    end
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
  endtask

  initial begin
    logic [NW-1:0] p;
    logic ew, lv;
    logic [4:0] ea, la;

    // Reset state
    #2;
    check_all();
    #10 rst_ni = 1'b1;
    @(posedge clk_int); #1;
    check_all();

    // EX write x5, one-cycle latency, then back to idle
    step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, '0);
    chk("ex_lat_addr", 64'(rf_waddr_o), 64'd5);
    chk("ex_lat_we", 64'(rf_we_o), 64'd1);
    idle(1);
    chk("ex_idle_we", 64'(rf_we_o), 64'd0);

    // LSU load x7: pending next cycle, written the cycle after, then cleared
    step(1'b0, 5'd0, '0, 1'b1, 5'd7, 32'h1234);
    chk("lsu_pend7", 64'(pend_mask_o[7]), 64'd1);
    chk("lsu_no_bypass", 64'(rf_we_o), 64'd0);
    idle(2);

    // Fill FIFO with x3/x4 while EX is busy; held x9 waits for space
    step(1'b1, 5'd10, 32'hA, 1'b1, 5'd3, 32'h33);
    step(1'b1, 5'd11, 32'hB, 1'b1, 5'd4, 32'h44);
    chk("full_ready", 64'(lsu_ready_o), 64'd0);
    step(1'b1, 5'd12, 32'hC, 1'b1, 5'd9, 32'h99);
    step(1'b0, 5'd0, '0, 1'b1, 5'd9, 32'h99);
    chk("drain_x3", 64'(rf_waddr_o), 64'd3);
    step(1'b0, 5'd0, '0, 1'b1, 5'd9, 32'h99);
    chk("drain_x4", 64'(rf_waddr_o), 64'd4);
    idle(3);

    // x0 writes from both sources (5'b10000 is x0 under RV32E)
    step(1'b1, 5'd0, 32'h1, 1'b1, 5'b10000, 32'h2);
    step(1'b1, 5'b10000, 32'h3, 1'b1, 5'd0, 32'h4);
    chk("x0_we", 64'(rf_we_o), 64'd0);
    chk("x0_pend", 64'(pend_mask_o), 64'd0);

    // Address bit 4 ignored under RV32E
    raddr_a_i = 5'b10011;
    step(1'b0, 5'd0, '0, 1'b1, 5'b10011, 32'h5A5A);
    chk("rv32e_haz_a", 64'(hazard_a_o), 64'd1);
    idle(1);
    chk("rv32e_waddr", 64'(rf_waddr_o), 64'd3);
    idle(1);

    // Randomized traffic; EX avoids registers with a pending write
    for (int i = 0; i < 600; i++) begin
      p  = model_pend();
      ew = ($urandom_range(0, 2) != 0);
      ea = 5'($urandom_range(0, 31));
      if (ew && msk(ea) != 5'd0 && p[msk(ea)]) ew = 1'b0;
      lv = ($urandom_range(0, 1) != 0);
      la = 5'($urandom_range(0, 31));
      raddr_a_i = 5'($urandom_range(0, 31));
      raddr_b_i = 5'($urandom_range(0, 31));
      step(ew, ea, $urandom, lv, la, $urandom);
    end
    idle(4);

    // Reset mid-operation: two buffered loads plus a write in flight
    step(1'b1, 5'd10, 32'hA, 1'b1, 5'd3, 32'h33);
    step(1'b1, 5'd11, 32'hB, 1'b1, 5'd4, 32'h44);
    chk("pre_rst_full", 64'(lsu_ready_o), 64'd0);
    raddr_a_i = 5'd3; raddr_b_i = 5'd11;
    ex_we_i = 1'b0; lsu_valid_i = 1'b0;
    rst_ni = 1'b0;
    q.delete(); m_we = 1'b0; m_addr = '0; m_data = '0;
    #1;
    check_all();
    @(posedge clk_int); #1;
    check_all();
    #2 rst_ni = 1'b1;
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
